game_state_ctrl: RTL and testbench

- Central game FSM register for the Tetris core. Consumes the registered next-state proposals and board images from the per-state worker blocks (initial, generate, move, clear).
- Drives the single authoritative game_current_state and blocks_exist board back to those workers.
- Generates the gravity drop tick and a stall watchdog.

---
 rtl/game_state_ctrl_pkg.sv | 21 ++
 rtl/game_state_ctrl_drop_timer.sv | 29 ++
 rtl/game_state_ctrl.sv | 145 ++++++++++++++
 tb/tb_game_state_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_state_ctrl_pkg.sv
// Shared definitions for the Tetris game controller: state codes, board geometry
// and the illegal-state-code check.
package game_state_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INITIAL   = 3'd0,
    ST_GENERATE  = 3'd1,
    ST_MOVE      = 3'd2,
    ST_CLEAR     = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_e;

  localparam int BOARD_W    = 10;
  localparam int BOARD_H    = 20;
  localparam int BOARD_BITS = BOARD_W * BOARD_H;

  function automatic logic is_illegal_state(input logic [2:0] code);
    return code > ST_GAME_OVER;
  endfunction

endpackage

// File: rtl/game_state_ctrl_drop_timer.sv
// Gravity timer: counts enabled cycles and emits a one-cycle tick every PERIOD
// enabled cycles; clear restarts the count.
module game_state_ctrl_drop_timer #(
  parameter int PERIOD = 25_000_000,
  parameter int CNT_W  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(PERIOD - 1));
  assign tick   = enable && w_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (clear)
      r_cnt <= '0;
    else if (enable)
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Central Tetris game FSM: arbitrates worker proposals, owns the board, drives
// gravity ticks and a stall watchdog. Optional pause input under GAME_PAUSE_EN.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int DROP_PERIOD = 25_000_000,
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rotate,
`ifdef GAME_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic [2:0]            game_next_state_initial,
  input  logic [BOARD_BITS-1:0] blocks_exist_initial,
  input  logic [2:0]            game_next_state_generate,
  input  logic [BOARD_BITS-1:0] blocks_exist_generate,
  input  logic [2:0]            game_next_state_move,
  input  logic [BOARD_BITS-1:0] blocks_exist_move,
  input  logic [2:0]            game_next_state_clear,
  input  logic [BOARD_BITS-1:0] blocks_exist_clear,
  output logic [2:0]            game_current_state,
  output logic [BOARD_BITS-1:0] blocks_exist,
  output logic                  state_entry,
  output logic                  drop_tick,
  output logic                  stall_fault
);

  logic [2:0]            r_state;
  logic                  r_entry;
  logic [BOARD_BITS-1:0] r_board;
  logic                  r_fault;
  logic [CNT_W-1:0]      r_stall;

  logic [2:0]            w_next_state;
  logic                  w_next_entry;
  logic [BOARD_BITS-1:0] w_next_board;
  logic                  w_next_fault;
  logic [CNT_W-1:0]      w_next_stall;

  logic [2:0]            w_prop;
  logic [BOARD_BITS-1:0] w_owner_board;
  logic                  w_stall_zone;
  logic                  w_watchdog;
  logic                  w_freeze;
  logic                  w_drop_en;
  logic                  w_tick;

`ifdef GAME_PAUSE_EN
  assign w_freeze = pause && (r_state == ST_MOVE);
`else
  assign w_freeze = 1'b0;
`endif

  assign w_stall_zone = (r_state == ST_GENERATE) || (r_state == ST_CLEAR);
  assign w_watchdog   = w_stall_zone && (r_stall == CNT_W'(STALL_LIMIT - 1));
  assign w_drop_en    = (r_state == ST_MOVE) && !r_entry && !w_freeze;

  game_state_ctrl_drop_timer #(
    .PERIOD (DROP_PERIOD),
    .CNT_W  (CNT_W)
  ) u_drop_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (w_drop_en),
    .clear  (r_entry),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_INITIAL;
      r_entry <= 1'b1;
      r_board <= '0;
      r_fault <= 1'b0;
      r_stall <= '0;
    end else begin
      r_state <= w_next_state;
      r_entry <= w_next_entry;
      r_board <= w_next_board;
      r_fault <= w_next_fault;
      r_stall <= w_next_stall;
    end
  end

  always_comb begin
    w_prop        = r_state;
    w_owner_board = r_board;
    case (r_state)
      ST_INITIAL:  begin w_prop = game_next_state_initial;  w_owner_board = blocks_exist_initial;  end
      ST_GENERATE: begin w_prop = game_next_state_generate; w_owner_board = blocks_exist_generate; end
      ST_MOVE:     begin w_prop = game_next_state_move;     w_owner_board = blocks_exist_move;     end
      ST_CLEAR:    begin w_prop = game_next_state_clear;    w_owner_board = blocks_exist_clear;    end
      default:     ;
    endcase

    w_next_state = r_state;
    w_next_entry = 1'b0;
    w_next_board = r_board;
    w_next_fault = r_fault;
    w_next_stall = w_stall_zone ? r_stall + CNT_W'(1) : '0;

    // Priority: pause freeze, watchdog, stale-entry hold, recovery, proposal.
    if (w_freeze) begin
      w_next_entry = r_entry;
      w_next_stall = r_stall;
    end else if (w_watchdog) begin
      w_next_state = ST_GAME_OVER;
      w_next_entry = 1'b1;
      w_next_fault = 1'b1;
      w_next_stall = '0;
    end else if (r_entry) begin
      w_next_entry = 1'b0;
    end else if (r_state == ST_GAME_OVER) begin
      if (rotate) begin
        w_next_state = ST_INITIAL;
        w_next_entry = 1'b1;
      end
    end else if (is_illegal_state(r_state) || is_illegal_state(w_prop)) begin
      // Recovery always counts as a fresh entry, even from INITIAL itself.
      w_next_state = ST_INITIAL;
      w_next_entry = 1'b1;
      w_next_board = '0;
      w_next_stall = '0;
    end else begin
      w_next_board = w_owner_board;
      if (w_prop != r_state) begin
        w_next_state = w_prop;
        w_next_entry = 1'b1;
        w_next_stall = '0;
      end
    end
  end

  always_comb begin
    game_current_state = r_state;
    blocks_exist       = r_board;
    state_entry        = r_entry;
    stall_fault        = r_fault;
    drop_tick          = w_tick;
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: directed scenarios then randomized
// traffic, checked against a cycle-age based reference model.
module tb_game_state_ctrl;

  localparam int DP = 4;
  localparam int SL = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rotate;
  logic         pause;
  logic [2:0]   prop [4];
  logic [199:0] bd   [4];

  logic [2:0]   o_state;
  logic [199:0] o_board;
  logic         o_entry, o_tick, o_fault;

  typedef struct {
    logic [2:0]   st;
    logic [199:0] bd;
    logic         ent;
    logic         tick;
    logic         fault;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: state, entry flag, board, cycles since entry,
  // unpaused MOVE cycles since entry, sticky fault.
  int           m_state;
  bit           m_entry;
  logic [199:0] m_board;
  int           m_age;
  int           m_run;
  bit           m_fault;

  always #5 clk = ~clk;

  game_state_ctrl #(
    .DROP_PERIOD (DP),
    .STALL_LIMIT (SL),
    .CNT_W       (8)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .rotate                   (rotate),
`ifdef GAME_PAUSE_EN
    .pause                    (pause),
`endif
    .game_next_state_initial  (prop[0]),
    .blocks_exist_initial     (bd[0]),
    .game_next_state_generate (prop[1]),
    .blocks_exist_generate    (bd[1]),
    .game_next_state_move     (prop[2]),
    .blocks_exist_move        (bd[2]),
    .game_next_state_clear    (prop[3]),
    .blocks_exist_clear       (bd[3]),
    .game_current_state       (o_state),
    .blocks_exist             (o_board),
    .state_entry              (o_entry),
    .drop_tick                (o_tick),
    .stall_fault              (o_fault)
  );

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; pop one expectation per cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state",       {197'd0, o_state}, {197'd0, e.st});
      chk("board",       o_board,           e.bd);
      chk("state_entry", {199'd0, o_entry}, {199'd0, e.ent});
      chk("drop_tick",   {199'd0, o_tick},  {199'd0, e.tick});
      chk("stall_fault", {199'd0, o_fault}, {199'd0, e.fault});
    end
  end

  function automatic logic [199:0] rnd_board();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
    return t[199:0];
  endfunction

  task automatic model_reset();
    m_state = 0; m_entry = 1'b1; m_board = '0;
    m_age = 0; m_run = 0; m_fault = 1'b0;
  endtask

  // Push expectation for the current cycle, then advance the model across the edge.
  task automatic cycle();
    exp_t         e;
    bit           paused;
    bit           go;
    int           ns;
    logic [199:0] nb;
`ifdef GAME_PAUSE_EN
    paused = pause && (m_state == 2);
`else
    paused = 1'b0;
`endif
    e.st    = 3'(m_state);
    e.bd    = m_board;
    e.ent   = m_entry;
    e.fault = m_fault;
    e.tick  = (m_state == 2) && !m_entry && !paused && (((m_run + 1) % DP) == 0);
    q.push_back(e);

    go = 1'b0; ns = m_state; nb = m_board;
    if (!rst_n) begin
      model_reset();
    end else if (!paused) begin
      if ((m_state == 1 || m_state == 3) && m_age == SL - 1) begin
        ns = 4; go = 1'b1; m_fault = 1'b1;
      end else if (m_entry) begin
        go = 1'b0;
      end else if (m_state == 4) begin
        if (rotate) begin ns = 0; go = 1'b1; end
      end else if (prop[m_state] > 3'd4) begin
        ns = 0; go = 1'b1; nb = '0;
      end else begin
        nb = bd[m_state];
        if (int'(prop[m_state]) != m_state) begin ns = int'(prop[m_state]); go = 1'b1; end
      end
      if (go) begin
        m_state = ns; m_entry = 1'b1; m_age = 0; m_run = 0;
      end else begin
        if (m_state == 2 && !m_entry) m_run++;
        m_entry = 1'b0;
        m_age++;
      end
      m_board = nb;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rotate = 1'b0; pause = 1'b0;
    for (int k = 0; k < 4; k++) begin prop[k] = 3'd0; bd[k] = '0; end
    @(posedge clk);
    #1;
    model_reset();
    cycle();

    // Reset release, then INITIAL -> GENERATE_PIECE
    rst_n = 1'b1;
    repeat (3) cycle();
    prop[0] = 3'd1; bd[0] = rnd_board();
    cycle();

    // Stale proposal during the GENERATE_PIECE entry cycle
    prop[1] = 3'd2; bd[1] = 200'hFF;
    cycle();
    cycle();

    // Drop ticks in MOVE, leave for CLEAR_LINES at cycle 6, then return
    prop[2] = 3'd2; bd[2] = 200'h1F0;
    repeat (6) cycle();
    prop[2] = 3'd3;
    cycle();
    prop[3] = 3'd3; bd[3] = rnd_board();
    repeat (4) cycle();
    prop[3] = 3'd2; prop[2] = 3'd2;
    cycle();
    repeat (10) cycle();

    // Illegal proposal from MOVE
    prop[2] = 3'd7;
    cycle();

    // Watchdog: GENERATE_PIECE stuck, then rotate out of GAME_OVER
    prop[1] = 3'd1; bd[1] = rnd_board();
    repeat (12) cycle();
    rotate = 1'b1;
    cycle();
    rotate = 1'b0; prop[0] = 3'd0;
    repeat (3) cycle();

`ifdef GAME_PAUSE_EN
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    prop[0] = 3'd1; prop[1] = 3'd2; prop[2] = 3'd2;
    repeat (6) cycle();
    pause = 1'b1;
    repeat (10) cycle();
    pause = 1'b0;
    repeat (8) cycle();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      rotate = ($urandom_range(0, 3) == 0);
`ifdef GAME_PAUSE_EN
      pause  = ($urandom_range(0, 4) == 0);
`endif
      for (int k = 0; k < 4; k++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 14)      prop[k] = (m_state <= 3) ? 3'(m_state) : 3'(k);
        else if (r < 19) prop[k] = 3'($urandom_range(0, 4));
        else             prop[k] = 3'($urandom_range(5, 7));
        bd[k] = rnd_board();
      end
      cycle();
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
